voice_scheduler: RTL and testbench

// - Sequences the three-voice chord datapath: accepts a stream of notes from the song reader and

---
 rtl/voice_scheduler.sv | 152 +++++++++++++++
 tb/tb_voice_scheduler.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_scheduler.sv
// voice_scheduler: assigns song notes to the lowest free note_player voice and groups them into chords; loads land 1 cycle after accept.
// note_ready drops while a load strobe is pending, no voice is free, or a closed chord drains; VOICE_STEAL_EN enables round-robin voice stealing.
module voice_scheduler #(
  parameter int NUM_VOICES = 3,
  parameter int NOTE_W     = 6,
  parameter int DUR_W      = 6
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         play_enable,
  input  logic                         note_valid,
  input  logic [NOTE_W-1:0]            note_in,
  input  logic [DUR_W-1:0]             duration_in,
  input  logic                         chord_last,
  output logic                         note_ready,
  input  logic [NUM_VOICES-1:0]        done_with_note,
  output logic [NUM_VOICES*NOTE_W-1:0] note_to_load,
  output logic [NUM_VOICES*DUR_W-1:0]  duration_to_load,
  output logic [NUM_VOICES-1:0]        load_new_note,
  output logic [NUM_VOICES-1:0]        voice_busy,
  output logic                         chord_done
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  typedef enum logic {
    ACCEPT     = 1'b0,
    WAIT_CHORD = 1'b1
  } state_t;

  state_t                       state_q, state_d;
  logic [NUM_VOICES-1:0]        busy_q, busy_d;
  logic [NUM_VOICES-1:0]        done_q;
  logic [NUM_VOICES-1:0]        load_q, load_d;
  logic [NUM_VOICES*NOTE_W-1:0] note_q, note_d;
  logic [NUM_VOICES*DUR_W-1:0]  dur_q, dur_d;
  logic                         chord_done_q, chord_done_d;

  logic [NUM_VOICES-1:0]        rise;
  logic                         any_free;
  logic                         load_pending;
  logic                         accept_ok;
  logic                         ready_int;
  logic                         xfer;
  logic [IDX_W-1:0]             free_idx;
  logic [IDX_W-1:0]             target;
`ifdef VOICE_STEAL_EN
  logic [IDX_W-1:0]             steal_ptr_q, steal_ptr_d;
`endif

  // Lowest-index free voice, judged only on busy state at the start of the cycle.
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int k = NUM_VOICES - 1; k >= 0; k--) begin
      if (!busy_q[k]) begin
        any_free = 1'b1;
        free_idx = IDX_W'(k);
      end
    end
  end

  always_comb begin
    rise         = done_with_note & ~done_q;
    load_pending = |load_q;
`ifdef VOICE_STEAL_EN
    accept_ok    = play_enable & ~load_pending;
    target       = any_free ? free_idx : steal_ptr_q;
    steal_ptr_d  = steal_ptr_q;
`else
    accept_ok    = play_enable & any_free & ~load_pending;
    target       = free_idx;
`endif
    ready_int    = (state_q == ACCEPT) & accept_ok;
    xfer         = note_valid & ready_int;

    load_d       = '0;
    note_d       = note_q;
    dur_d        = dur_q;
    // A done edge landing on the strobe cycle is ignored: the fresh load wins.
    busy_d       = busy_q & ~(rise & ~load_q);
    for (int k = 0; k < NUM_VOICES; k++) begin
      if (xfer && (target == IDX_W'(k))) begin
        load_d[k]                   = 1'b1;
        busy_d[k]                   = 1'b1;
        note_d[k*NOTE_W +: NOTE_W]  = note_in;
        dur_d[k*DUR_W +: DUR_W]     = duration_in;
      end
    end
`ifdef VOICE_STEAL_EN
    if (xfer && !any_free) begin
      steal_ptr_d = (steal_ptr_q == IDX_W'(NUM_VOICES - 1)) ? '0 : steal_ptr_q + 1'b1;
    end
`endif

    state_d      = state_q;
    chord_done_d = 1'b0;
    case (state_q)
      ACCEPT: begin
        if (xfer && chord_last) begin
          state_d = WAIT_CHORD;
        end
      end
      WAIT_CHORD: begin
        // Judged on next-cycle busy so chord_done, busy clearing and note_ready line up.
        if (play_enable && (busy_d == '0) && (load_d == '0)) begin
          state_d      = ACCEPT;
          chord_done_d = 1'b1;
        end
      end
      default: state_d = ACCEPT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ACCEPT;
      busy_q       <= '0;
      done_q       <= '0;
      load_q       <= '0;
      note_q       <= '0;
      dur_q        <= '0;
      chord_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_with_note;
      load_q       <= load_d;
      note_q       <= note_d;
      dur_q        <= dur_d;
      chord_done_q <= chord_done_d;
    end
  end

`ifdef VOICE_STEAL_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      steal_ptr_q <= '0;
    end else begin
      steal_ptr_q <= steal_ptr_d;
    end
  end
`endif

  assign note_ready       = reset & ready_int;
  assign note_to_load     = note_q;
  assign duration_to_load = dur_q;
  assign load_new_note    = load_q;
  assign voice_busy       = busy_q;
  assign chord_done       = chord_done_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler: stimulus pushes expected loads/chord completions, a negedge monitor pops and compares.
module tb_voice_scheduler;

  localparam int NV = 3;
  localparam int NW = 6;
  localparam int DW = 6;

  logic             clk = 1'b0;
  logic             reset;
  logic             play_enable;
  logic             note_valid;
  logic [NW-1:0]    note_in;
  logic [DW-1:0]    duration_in;
  logic             chord_last;
  logic             note_ready;
  logic [NV-1:0]    done_with_note;
  logic [NV*NW-1:0] note_to_load;
  logic [NV*DW-1:0] duration_to_load;
  logic [NV-1:0]    load_new_note;
  logic [NV-1:0]    voice_busy;
  logic             chord_done;

  typedef struct {
    int          voice;
    logic [NW-1:0] note;
    logic [DW-1:0] dur;
  } load_exp_t;

  load_exp_t load_exp_q[$];
  int        chord_exp_q[$];
  load_exp_t mon_e;
  int        mon_c;
  int        checks = 0;
  int        errors = 0;

  always #5 clk = ~clk;

  voice_scheduler #(.NUM_VOICES(NV), .NOTE_W(NW), .DUR_W(DW)) dut (
    .clk              (clk),
    .reset            (reset),
    .play_enable      (play_enable),
    .note_valid       (note_valid),
    .note_in          (note_in),
    .duration_in      (duration_in),
    .chord_last       (chord_last),
    .note_ready       (note_ready),
    .done_with_note   (done_with_note),
    .note_to_load     (note_to_load),
    .duration_to_load (duration_to_load),
    .load_new_note    (load_new_note),
    .voice_busy       (voice_busy),
    .chord_done       (chord_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one note, wait (bounded) for acceptance; returns in the strobe cycle.
  task automatic send(input logic [NW-1:0] n, input logic [DW-1:0] d, input logic last,
                      input int exp_voice);
    load_exp_t e;
    int waited;
    waited      = 0;
    note_in     = n;
    duration_in = d;
    chord_last  = last;
    note_valid  = 1'b1;
    @(negedge clk);
    while (!note_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!note_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: note %0d not accepted after %0d cycles", n, waited);
    end else begin
      e.voice = exp_voice;
      e.note  = n;
      e.dur   = d;
      load_exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    note_valid = 1'b0;
    chord_last = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (load_new_note != '0) begin
        if (load_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_load: strobe %b with nothing expected", load_new_note);
        end else begin
          mon_e = load_exp_q.pop_front();
          check("load_strobe", 32'(load_new_note), 32'(1) << mon_e.voice);
          check("load_note", 32'(note_to_load[mon_e.voice*NW +: NW]), 32'(mon_e.note));
          check("load_dur", 32'(duration_to_load[mon_e.voice*DW +: DW]), 32'(mon_e.dur));
        end
      end
      if (chord_done) begin
        if (chord_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_chord_done: pulse with nothing expected");
        end else begin
          mon_c = chord_exp_q.pop_front();
          checks++;
        end
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    reset          = 1'b0;
    play_enable    = 1'b1;
    note_valid     = 1'b0;
    note_in        = '0;
    duration_in    = '0;
    chord_last     = 1'b0;
    done_with_note = '0;

    // T1 reset
    tick(2);
    @(negedge clk);
    check("rst_ready", note_ready, 0);
    check("rst_load", load_new_note, 0);
    check("rst_busy", voice_busy, 0);
    check("rst_chord_done", chord_done, 0);
    check("rst_note_bus", note_to_load, 0);
    check("rst_dur_bus", duration_to_load, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("t1_ready", note_ready, 1);
    check("t1_busy", voice_busy, 0);
    tick(1);

    // T2 single-note chord
    send(6'd9, 6'd4, 1'b1, 0);
    @(negedge clk);
    check("t2_ready_strobe", note_ready, 0);
    check("t2_busy", voice_busy, 3'b001);
    tick(1);
    done_with_note = 3'b001;
    chord_exp_q.push_back(2);
    tick(1);
    @(negedge clk);
    check("t2_busy_clear", voice_busy, 0);
    check("t2_chord_done", chord_done, 1);
    check("t2_ready_again", note_ready, 1);
    tick(1);
    done_with_note = '0;
    tick(1);

    // T3 triad
    send(6'd5, 6'd3, 1'b0, 0);
    send(6'd9, 6'd3, 1'b0, 1);
    send(6'd12, 6'd3, 1'b1, 2);
    tick(1);
    done_with_note = 3'b011;
    tick(1);
    @(negedge clk);
    check("t3_busy_partial", voice_busy, 3'b100);
    check("t3_no_early_done", chord_done, 0);
    check("t3_ready_waiting", note_ready, 0);
    check("t3_note_bus", note_to_load, {6'd12, 6'd9, 6'd5});
    check("t3_dur_bus", duration_to_load, {6'd3, 6'd3, 6'd3});
    tick(1);
    done_with_note = 3'b111;
    chord_exp_q.push_back(3);
    tick(1);
    @(negedge clk);
    check("t3_chord_done", chord_done, 1);
    check("t3_busy_clear", voice_busy, 0);
    tick(1);
    done_with_note = '0;
    tick(1);

    // T4 chord wider than the voice count
    send(6'd1, 6'd2, 1'b0, 0);
    send(6'd2, 6'd2, 1'b0, 1);
    send(6'd3, 6'd2, 1'b0, 2);
`ifdef VOICE_STEAL_EN
    send(6'd4, 6'd7, 1'b1, 0);
    @(negedge clk);
    check("t4_steal_busy", voice_busy, 3'b111);
`else
    note_in     = 6'd4;
    duration_in = 6'd7;
    chord_last  = 1'b1;
    note_valid  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t4_stall_ready", note_ready, 0);
    end
    check("t4_stall_busy", voice_busy, 3'b111);
    tick(1);
    done_with_note = 3'b010;
    send(6'd4, 6'd7, 1'b1, 1);
    @(negedge clk);
    check("t4_reload_busy", voice_busy, 3'b111);
`endif
    tick(1);
    done_with_note = '0;
    tick(1);
    done_with_note = 3'b111;
    chord_exp_q.push_back(4);
    tick(2);
    @(negedge clk);
    check("t4_busy_end", voice_busy, 0);
    tick(1);
    done_with_note = '0;
    tick(1);

    // T5 play_enable hold, then done edge colliding with a load strobe
    play_enable = 1'b0;
    note_in     = 6'd20;
    duration_in = 6'd1;
    chord_last  = 1'b0;
    note_valid  = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("t5_hold_ready", note_ready, 0);
      check("t5_hold_load", load_new_note, 0);
    end
    tick(1);
    play_enable = 1'b1;
    send(6'd20, 6'd1, 1'b0, 0);
    send(6'd21, 6'd1, 1'b0, 1);
    send(6'd22, 6'd1, 1'b1, 2);
    done_with_note = 3'b100;
    tick(2);
    @(negedge clk);
    check("t5_collision_busy", voice_busy, 3'b111);
    check("t5_wait_ready", note_ready, 0);

    // T6 async reset in WAIT_CHORD with two voices busy
    tick(1);
    done_with_note = '0;
    tick(1);
    done_with_note = 3'b100;
    tick(2);
    @(negedge clk);
    check("t6_pre_busy", voice_busy, 3'b011);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_ready", note_ready, 0);
    check("t6_rst_busy", voice_busy, 0);
    check("t6_rst_load", load_new_note, 0);
    check("t6_rst_chord_done", chord_done, 0);
    check("t6_rst_note_bus", note_to_load, 0);
    check("t6_rst_dur_bus", duration_to_load, 0);
    done_with_note = '0;
    tick(1);
    reset = 1'b1;
    @(negedge clk);
    check("t6_post_ready", note_ready, 1);
    check("t6_post_busy", voice_busy, 0);
    tick(1);

    // Zero duration passes through untouched on the lowest voice
    send(6'd33, 6'd0, 1'b1, 0);
    tick(1);
    done_with_note = 3'b001;
    chord_exp_q.push_back(6);
    tick(3);
    done_with_note = '0;
    tick(2);

    check("load_queue_drained", load_exp_q.size(), 0);
    check("chord_queue_drained", chord_exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
